// File: rtl/audio_dac_serializer.sv
// Mono sample buffer and left-justified 16-bit serializer driving the codec DAC pins as clock master.
module audio_dac_serializer #(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        frame_start,
    output logic        underrun,
    input  logic        clr_underrun,
    output logic        AUD_BCLK,
    output logic        AUD_DACLRCK,
    output logic        AUD_DACDAT
);

    localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned BIT_W = 5;
    localparam int unsigned SMP_W = 16;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(31);
    localparam logic [BIT_W-1:0] BIT_LHALF = BIT_W'(15);

    logic [DIV_W-1:0] div_cnt,     div_cnt_nxt;
    logic [BIT_W-1:0] bit_cnt,     bit_cnt_nxt;
    logic [SMP_W-1:0] shift,       shift_nxt;
    logic [SMP_W-1:0] shadow,      shadow_nxt;
    logic [SMP_W-1:0] buffer,      buffer_nxt;
    logic             buffer_full, buffer_full_nxt;
    logic             bclk_nxt;
    logic             lrck_nxt;
    logic             ready_nxt;
    logic             frame_start_nxt;
    logic             underrun_nxt;

    logic div_wrap_c;
    logic fall_tick_c;
    logic frame_load_c;
    logic right_load_c;
    logic write_c;

    // Event decode: divider wrap, BCLK falling toggle, slot boundaries, handshake
    always_comb begin
        div_wrap_c   = (div_cnt == DIV_LAST);
        fall_tick_c  = div_wrap_c && AUD_BCLK;
        frame_load_c = fall_tick_c && (bit_cnt == BIT_LAST);
        right_load_c = fall_tick_c && (bit_cnt == BIT_LHALF);
        write_c      = sample_valid && sample_ready;
    end

    // Next-state logic for divider, bit counter, shifter, buffer and status flags
    always_comb begin
        div_cnt_nxt     = div_wrap_c ? '0 : div_cnt + DIV_W'(1);
        bclk_nxt        = div_wrap_c ? ~AUD_BCLK : AUD_BCLK;
        bit_cnt_nxt     = bit_cnt;
        shift_nxt       = shift;
        shadow_nxt      = shadow;
        buffer_nxt      = buffer;
        buffer_full_nxt = buffer_full;
        underrun_nxt    = underrun;
        frame_start_nxt = frame_load_c;

        if (clr_underrun) begin
            underrun_nxt = 1'b0;
        end

        if (fall_tick_c) begin
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
            if (frame_load_c) begin
                if (buffer_full) begin
                    shadow_nxt      = buffer;
                    shift_nxt       = buffer;
                    buffer_full_nxt = 1'b0;
                end else begin
                    // Starved frame: repeat the previous sample; set beats clear
                    shift_nxt    = shadow;
                    underrun_nxt = 1'b1;
                end
            end else if (right_load_c) begin
                shift_nxt = shadow;
            end else begin
                shift_nxt = {shift[SMP_W-2:0], 1'b0};
            end
        end

        // Only possible while empty, so it never races the load's consume
        if (write_c) begin
            buffer_nxt      = sample_in;
            buffer_full_nxt = 1'b1;
        end

        lrck_nxt  = ~bit_cnt_nxt[BIT_W-1];
        ready_nxt = ~buffer_full_nxt;
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            div_cnt      <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            shadow       <= '0;
            buffer       <= '0;
            buffer_full  <= 1'b0;
            AUD_BCLK     <= 1'b0;
            AUD_DACLRCK  <= 1'b1;
            sample_ready <= 1'b1;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            div_cnt      <= div_cnt_nxt;
            bit_cnt      <= bit_cnt_nxt;
            shift        <= shift_nxt;
            shadow       <= shadow_nxt;
            buffer       <= buffer_nxt;
            buffer_full  <= buffer_full_nxt;
            AUD_BCLK     <= bclk_nxt;
            AUD_DACLRCK  <= lrck_nxt;
            sample_ready <= ready_nxt;
            frame_start  <= frame_start_nxt;
            underrun     <= underrun_nxt;
        end
    end

    // Serial data is the shifter MSB, itself a flop
    assign AUD_DACDAT = shift[SMP_W-1];

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer with hand-computed expectations (BCLK_DIV = 4).
module tb_audio_dac_serializer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        frame_start;
    logic        underrun;
    logic        clr_underrun = 1'b0;
    logic        AUD_BCLK;
    logic        AUD_DACLRCK;
    logic        AUD_DACDAT;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;

    audio_dac_serializer #(.BCLK_DIV(4)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .frame_start  (frame_start),
        .underrun     (underrun),
        .clr_underrun (clr_underrun),
        .AUD_BCLK     (AUD_BCLK),
        .AUD_DACLRCK  (AUD_DACLRCK),
        .AUD_DACDAT   (AUD_DACDAT)
    );

    always #5 Clk = ~Clk;

    // Single comparison point: counts and reports
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance one Clk edge and settle
    task automatic tick();
        @(posedge Clk);
        #1;
        edge_n++;
    endtask

    // Release reset just after an edge; edge_n counts edges from release
    task automatic release_reset();
        @(posedge Clk);
        #1;
        Reset  = 1'b0;
        edge_n = 0;
    endtask

    // Step until frame_start is seen (the edge right after a frame load), bounded
    task automatic wait_load(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_start && n < 400);
        if (!frame_start) check("load_timeout", 32'(n), 32'(256));
    endtask

    // Capture one frame starting at a load edge; pre = edges already elapsed since it
    task automatic capture(input string tag, input int pre, input logic [15:0] exp);
        logic [31:0] dat;
        logic [31:0] lr;
        dat = '0;
        lr  = '0;
        for (int i = 0; i < 32; i++) begin
            dat[31-i] = AUD_DACDAT;
            lr[31-i]  = AUD_DACLRCK;
            repeat ((i == 0) ? 8 - pre : 8) tick();
        end
        check({tag, "_left"},  32'(dat[31:16]), 32'(exp));
        check({tag, "_right"}, 32'(dat[15:0]),  32'(exp));
        check({tag, "_lrck"},  lr, 32'hFFFF_0000);
    endtask

    initial begin
        int n;
        int err_bclk;
        int err_lrck;
        int err_dat;
        int err_ur;

        // ---- Reset / idle ----
        repeat (3) @(posedge Clk);
        #1;
        check("rst_bclk",  32'(AUD_BCLK),     32'd0);
        check("rst_lrck",  32'(AUD_DACLRCK),  32'd1);
        check("rst_dat",   32'(AUD_DACDAT),   32'd0);
        check("rst_ready", 32'(sample_ready), 32'd1);
        check("rst_fs",    32'(frame_start),  32'd0);
        check("rst_ur",    32'(underrun),     32'd0);
        release_reset();
        err_bclk = 0; err_lrck = 0; err_dat = 0; err_ur = 0;
        for (int e = 1; e <= 256; e++) begin
            tick();
            if (AUD_BCLK !== 1'((e / 4) % 2)) err_bclk++;
            if (AUD_DACLRCK !== 1'(((e / 8) % 32) < 16)) err_lrck++;
            if (AUD_DACDAT !== 1'b0) err_dat++;
            if (e < 256 && underrun !== 1'b0) err_ur++;
            if (e == 3) check("idle_bclk_e3", 32'(AUD_BCLK), 32'd0);
            if (e == 4) check("idle_bclk_e4", 32'(AUD_BCLK), 32'd1);
            if (e == 8) check("idle_bclk_e8", 32'(AUD_BCLK), 32'd0);
        end
        check("idle_bclk_pattern", 32'(err_bclk), 32'd0);
        check("idle_lrck_pattern", 32'(err_lrck), 32'd0);
        check("idle_dat_zero",     32'(err_dat),  32'd0);
        check("idle_ur_early",     32'(err_ur),   32'd0);
        check("idle_ur_e256",      32'(underrun), 32'd1);
        check("idle_fs_e256",      32'(frame_start), 32'd1);
        tick();
        check("idle_fs_e257",      32'(frame_start), 32'd0);

        // ---- Single sample after fresh reset ----
        Reset = 1'b1;
        #1;
        release_reset();
        repeat (9) tick();
        check("single_ready_e9", 32'(sample_ready), 32'd1);
        sample_in = 16'hA5C3; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("single_ready_e10", 32'(sample_ready), 32'd0);
        repeat (245) tick();
        check("single_ready_e255", 32'(sample_ready), 32'd0);
        tick();
        check("single_ready_e256", 32'(sample_ready), 32'd1);
        check("single_fs_e256",    32'(frame_start),  32'd1);
        check("single_ur_e256",    32'(underrun),     32'd0);
        check("single_msb_e256",   32'(AUD_DACDAT),   32'd1);
        capture("single", 0, 16'hA5C3);

        // ---- Back-pressure ----
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
        check("bp_ur_cleared", 32'(underrun), 32'd0);
        sample_in = 16'h7FFF; sample_valid = 1'b1;
        tick();
        sample_in = 16'h8000;
        check("bp_ready_full", 32'(sample_ready), 32'd0);
        wait_load(n);
        check("bp_ready_load", 32'(sample_ready), 32'd1);
        check("bp_msb_7fff",   32'(AUD_DACDAT),   32'd0);
        tick();
        sample_valid = 1'b0;
        check("bp_second_taken", 32'(sample_ready), 32'd0);
        capture("bp_7fff", 1, 16'h7FFF);
        check("bp_ur_after", 32'(underrun), 32'd0);
        capture("bp_8000", 0, 16'h8000);

        // ---- Underrun repeat ----
        sample_in = 16'h1234; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
        wait_load(n);
        check("ur_loaded_clean", 32'(underrun), 32'd0);
        capture("ur_f0", 0, 16'h1234);
        capture("ur_f1", 0, 16'h1234);
        capture("ur_f2", 0, 16'h1234);
        check("ur_sticky", 32'(underrun), 32'd1);
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
        check("ur_cleared", 32'(underrun), 32'd0);
        sample_in = 16'h5A5A; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        wait_load(n);
        check("ur_load_ok", 32'(underrun), 32'd0);

        // ---- Same-cycle write on a starved load edge (with clear: set wins) ----
        repeat (255) tick();
        sample_in = 16'hC001; sample_valid = 1'b1; clr_underrun = 1'b1;
        tick();
        sample_valid = 1'b0; clr_underrun = 1'b0;
        check("edge_fs",    32'(frame_start),  32'd1);
        check("edge_ur",    32'(underrun),     32'd1);
        check("edge_ready", 32'(sample_ready), 32'd0);
        capture("edge_old", 0, 16'h5A5A);
        capture("edge_new", 0, 16'hC001);

        // ---- Reset mid-frame with the buffer full ----
        sample_in = 16'h0F0F; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        repeat (162) tick();
        check("mid_lrck_right", 32'(AUD_DACLRCK),  32'd0);
        check("mid_ready_full", 32'(sample_ready), 32'd0);
        Reset = 1'b1;
        #1;
        check("mid_rst_bclk",  32'(AUD_BCLK),     32'd0);
        check("mid_rst_lrck",  32'(AUD_DACLRCK),  32'd1);
        check("mid_rst_dat",   32'(AUD_DACDAT),   32'd0);
        check("mid_rst_ready", 32'(sample_ready), 32'd1);
        check("mid_rst_ur",    32'(underrun),     32'd0);
        release_reset();
        repeat (3) tick();
        check("mid_bclk_e3", 32'(AUD_BCLK), 32'd0);
        tick();
        check("mid_bclk_e4", 32'(AUD_BCLK), 32'd1);
        wait_load(n);
        check("mid_first_load_edge", 32'(n + 4), 32'd256);
        check("mid_buffer_emptied",  32'(underrun), 32'd1);
        capture("mid_zero", 0, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
